// File: rtl/mul_pkg.sv
// Shared types and helpers for the multiplier result-preparation pipeline.
package mul_pkg;

  typedef enum logic [1:0] {
    CLS_NORM = 2'b00,
    CLS_ZERO = 2'b01,
    CLS_INF  = 2'b10,
    CLS_NAN  = 2'b11
  } spec_cls_e;

  function automatic int bias(input int expo_w);
    return (1 << (expo_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/mul1_res_core.sv
// Stage-1 combinational logic: product sign/exponent, mantissa leading-zero
// analysis, normalisation shift amounts and special-value classification.
module mul1_res_core
  import mul_pkg::*;
#(
  parameter int SIGN_W = 1,
  parameter int EXPO_W = 8,
  parameter int MANT_W = 23,
  localparam int ZERO_D = $clog2(MANT_W + 1),
  localparam int EW     = EXPO_W + 2,
  localparam int SW     = ZERO_D + 1
) (
  input  logic [SIGN_W-1:0] a_sign,
  input  logic [SIGN_W-1:0] b_sign,
  input  logic [EXPO_W-1:0] a_expo,
  input  logic [EXPO_W-1:0] b_expo,
  input  logic [MANT_W-1:0] a_mant,
  input  logic [MANT_W-1:0] b_mant,
  output logic [SIGN_W-1:0] sign_1,
  output logic [EW-1:0]     expo_1,
  output logic [ZERO_D-1:0] zero_nums_uc,
  output logic [MANT_W:0]   mask_short,
  output logic [SW-1:0]     r_shift,
  output logic [SW-1:0]     l_shift,
  output spec_cls_e         spec_cls
);

  localparam logic [EW-1:0] BIAS_V = EW'(bias(EXPO_W));

  logic          a_sub, b_sub;
  logic [EW-1:0] ea, eb, diff, em1;
  logic [MANT_W:0] mant_input;
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  assign a_sub  = (a_expo == '0);
  assign b_sub  = (b_expo == '0);
  assign sign_1 = a_sign ^ b_sign;

  // Subnormals use an effective exponent of 1.
  assign ea     = a_sub ? EW'(1) : EW'(a_expo);
  assign eb     = b_sub ? EW'(1) : EW'(b_expo);
  assign expo_1 = ea + eb - BIAS_V;

  always_comb begin
    mant_input = {1'b1, {MANT_W{1'b0}}};
    if (a_sub)      mant_input = {1'b0, a_mant};
    else if (b_sub) mant_input = {1'b0, b_mant};
  end

  // Highest set bit wins; an all-zero input saturates at MANT_W.
  always_comb begin
    zero_nums_uc = ZERO_D'(MANT_W);
    for (int i = 0; i <= MANT_W; i++)
      if (mant_input[i]) zero_nums_uc = ZERO_D'(MANT_W - i);
  end

  always_comb begin
    mask_short = '0;
    for (int i = 0; i <= MANT_W; i++)
      mask_short[i] = |(mant_input >> i);
  end

  assign diff = EW'(1) - expo_1;
  assign em1  = expo_1 - EW'(1);

  always_comb begin
    r_shift = '0;
    l_shift = '0;
    if ($signed(expo_1) < $signed(EW'(1))) begin
      r_shift = (diff > EW'(MANT_W + 2)) ? SW'(MANT_W + 2) : diff[SW-1:0];
    end else begin
      l_shift = (em1 > EW'(zero_nums_uc)) ? SW'(zero_nums_uc) : em1[SW-1:0];
    end
  end

  assign a_nan  = (&a_expo) && (a_mant != '0);
  assign b_nan  = (&b_expo) && (b_mant != '0);
  assign a_inf  = (&a_expo) && (a_mant == '0);
  assign b_inf  = (&b_expo) && (b_mant == '0);
  assign a_zero = a_sub && (a_mant == '0);
  assign b_zero = b_sub && (b_mant == '0);

  always_comb begin
    spec_cls = CLS_NORM;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) spec_cls = CLS_NAN;
    else if (a_inf || b_inf)                                      spec_cls = CLS_INF;
    else if (a_zero || b_zero)                                    spec_cls = CLS_ZERO;
  end

endmodule

// File: rtl/mul1_res_pipe.sv
// Valid/ready pipeline carrying the stage-1 multiplier result fields through
// STAGES register stages; all arithmetic happens once in mul1_res_core.
module mul1_res_pipe
  import mul_pkg::*;
#(
  parameter int SIGN_W = 1,
  parameter int EXPO_W = 8,
  parameter int MANT_W = 23,
  parameter int STAGES = 2,
  localparam int ZERO_D = $clog2(MANT_W + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SIGN_W-1:0]   a_sign,
  input  logic [SIGN_W-1:0]   b_sign,
  input  logic [EXPO_W-1:0]   a_expo,
  input  logic [EXPO_W-1:0]   b_expo,
  input  logic [MANT_W-1:0]   a_mant,
  input  logic [MANT_W-1:0]   b_mant,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SIGN_W-1:0]   sign_1,
  output logic [EXPO_W+1:0]   expo_1,
  output logic [ZERO_D-1:0]   zero_nums_uc,
  output logic [MANT_W:0]     mask_short,
  output logic [ZERO_D:0]     r_shift,
  output logic [ZERO_D:0]     l_shift,
  output logic [1:0]          spec_cls
);

  localparam int DW = SIGN_W + (EXPO_W + 2) + ZERO_D + (MANT_W + 1) + 2 * (ZERO_D + 1) + 2;

  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("mul1_res_pipe: STAGES must be in 1..4");
  end

  logic [SIGN_W-1:0] c_sign;
  logic [EXPO_W+1:0] c_expo;
  logic [ZERO_D-1:0] c_lz;
  logic [MANT_W:0]   c_mask;
  logic [ZERO_D:0]   c_r, c_l;
  spec_cls_e         c_cls;

  mul1_res_core #(
    .SIGN_W(SIGN_W), .EXPO_W(EXPO_W), .MANT_W(MANT_W)
  ) u_core (
    .a_sign(a_sign), .b_sign(b_sign), .a_expo(a_expo), .b_expo(b_expo),
    .a_mant(a_mant), .b_mant(b_mant), .sign_1(c_sign), .expo_1(c_expo),
    .zero_nums_uc(c_lz), .mask_short(c_mask), .r_shift(c_r), .l_shift(c_l),
    .spec_cls(c_cls)
  );

  logic [DW-1:0]             d_in;
  logic [STAGES:1][DW-1:0]   data_q;
  logic [STAGES:1]           vld_pipe;
  logic [STAGES:1]           rdy;

  assign d_in = {c_sign, c_expo, c_lz, c_mask, c_r, c_l, c_cls};

  // Stage k can take data if any stage from k to the output has a hole.
  for (genvar k = 1; k <= STAGES; k++) begin : g_rdy
    assign rdy[k] = out_ready | ~(&vld_pipe[STAGES:k]);
  end

  assign in_ready  = rdy[1] & ~flush;
  assign out_valid = vld_pipe[STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      data_q   <= '0;
    end else if (flush) begin
      vld_pipe <= '0;
    end else begin
      if (rdy[1]) vld_pipe[1] <= in_valid;
      if (rdy[1] && in_valid) data_q[1] <= d_in;
      for (int k = 2; k <= STAGES; k++) begin
        if (rdy[k]) begin
          vld_pipe[k] <= vld_pipe[k-1];
          if (vld_pipe[k-1]) data_q[k] <= data_q[k-1];
        end
      end
    end
  end

  assign {sign_1, expo_1, zero_nums_uc, mask_short, r_shift, l_shift, spec_cls} = data_q[STAGES];

endmodule

// File: tb/tb_mul1_res_pipe.sv
// Directed bench for mul1_res_pipe (fp32, STAGES=2): vector table plus
// backpressure, flush and mid-stream reset sequences.
module tb_mul1_res_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [0:0]  a_sign = '0, b_sign = '0;
  logic [7:0]  a_expo = '0, b_expo = '0;
  logic [22:0] a_mant = '0, b_mant = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [0:0]  sign_1;
  logic [9:0]  expo_1;
  logic [4:0]  zero_nums_uc;
  logic [23:0] mask_short;
  logic [5:0]  r_shift, l_shift;
  logic [1:0]  spec_cls;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mul1_res_pipe #(.SIGN_W(1), .EXPO_W(8), .MANT_W(23), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .a_sign(a_sign), .b_sign(b_sign), .a_expo(a_expo), .b_expo(b_expo),
    .a_mant(a_mant), .b_mant(b_mant), .out_valid(out_valid), .out_ready(out_ready),
    .sign_1(sign_1), .expo_1(expo_1), .zero_nums_uc(zero_nums_uc),
    .mask_short(mask_short), .r_shift(r_shift), .l_shift(l_shift), .spec_cls(spec_cls)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        as_, bs_;
    logic [7:0]  ae, be;
    logic [22:0] am, bm;
    logic        x_sign;
    logic [9:0]  x_expo;
    logic [4:0]  x_lz;
    logic [23:0] x_mask;
    logic [5:0]  x_r, x_l;
    logic [1:0]  x_cls;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{"one_x_one",   0,0, 127,127, 23'h0,      23'h0,      0, 10'd127, 5'd0,  24'hFFFFFF, 6'd0,  6'd0,  2'b00};
    vecs[1]  = '{"sub_x_big",   0,0, 0,  137, 23'h1,      23'h0,      0, 10'd11,  5'd23, 24'h000001, 6'd0,  6'd10, 2'b00};
    vecs[2]  = '{"tiny_rsat",   0,0, 1,  1,   23'h0,      23'h0,      0, 10'h383, 5'd0,  24'hFFFFFF, 6'd25, 6'd0,  2'b00};
    vecs[3]  = '{"nan_x_one",   0,1, 255,127, 23'h1,      23'h0,      1, 10'd255, 5'd0,  24'hFFFFFF, 6'd0,  6'd0,  2'b11};
    vecs[4]  = '{"inf_x_zero",  0,0, 255,0,   23'h0,      23'h0,      0, 10'd129, 5'd23, 24'h000000, 6'd0,  6'd23, 2'b11};
    vecs[5]  = '{"inf_x_two",   1,1, 255,128, 23'h0,      23'h0,      0, 10'd256, 5'd0,  24'hFFFFFF, 6'd0,  6'd0,  2'b10};
    vecs[6]  = '{"zero_x_three",0,0, 0,  128, 23'h0,      23'h400000, 0, 10'd2,   5'd23, 24'h000000, 6'd0,  6'd1,  2'b01};
    vecs[7]  = '{"sub_hi_bit",  1,0, 0,  100, 23'h400000, 23'h0,      1, 10'h3E6, 5'd1,  24'h7FFFFF, 6'd25, 6'd0,  2'b00};
    vecs[8]  = '{"rshift_8",    0,0, 60, 60,  23'h0,      23'h0,      0, 10'h3F9, 5'd0,  24'hFFFFFF, 6'd8,  6'd0,  2'b00};
    vecs[9]  = '{"expo_zero",   0,0, 63, 64,  23'h0,      23'h0,      0, 10'd0,   5'd0,  24'hFFFFFF, 6'd1,  6'd0,  2'b00};
    vecs[10] = '{"b_sub_lmin",  0,0, 130,0,   23'h0,      23'h000F00, 0, 10'd4,   5'd12, 24'h000FFF, 6'd0,  6'd3,  2'b00};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(|{sign_1, expo_1, zero_nums_uc, mask_short, r_shift, l_shift, spec_cls}), 0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);

    // Table vectors: single item, result expected 2 edges after acceptance
    foreach (vecs[i]) begin
      @(negedge clk);
      a_sign = vecs[i].as_; b_sign = vecs[i].bs_;
      a_expo = vecs[i].ae;  b_expo = vecs[i].be;
      a_mant = vecs[i].am;  b_mant = vecs[i].bm;
      in_valid = 1'b1;
      #1;
      chk({vecs[i].name, "_in_ready"}, 32'(in_ready), 1);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk({vecs[i].name, "_not_early"}, 32'(out_valid), 0);
      @(negedge clk);
      chk({vecs[i].name, "_valid"}, 32'(out_valid), 1);
      chk({vecs[i].name, "_sign"},  32'(sign_1), 32'(vecs[i].x_sign));
      chk({vecs[i].name, "_expo"},  32'(expo_1), 32'(vecs[i].x_expo));
      chk({vecs[i].name, "_lz"},    32'(zero_nums_uc), 32'(vecs[i].x_lz));
      chk({vecs[i].name, "_mask"},  32'(mask_short), 32'(vecs[i].x_mask));
      chk({vecs[i].name, "_r"},     32'(r_shift), 32'(vecs[i].x_r));
      chk({vecs[i].name, "_l"},     32'(l_shift), 32'(vecs[i].x_l));
      chk({vecs[i].name, "_cls"},   32'(spec_cls), 32'(vecs[i].x_cls));
    end
    @(negedge clk);
    chk("drain_empty", 32'(out_valid), 0);

    // Backpressure: 5 items, consumer stalled for cycles 0..3
    begin
      int sent = 0, recv = 0;
      int ret_cyc[5];
      for (int c = 0; c < 30 && recv < 5; c++) begin
        @(negedge clk);
        out_ready = (c >= 4);
        in_valid  = (sent < 5);
        a_sign = 0; b_sign = 0; a_mant = 0; b_mant = 0;
        a_expo = 8'(100 + sent); b_expo = 8'd127;
        #1;
        if (c == 2 || c == 3) begin
          chk($sformatf("bp_in_ready_low_c%0d", c), 32'(in_ready), 0);
          chk($sformatf("bp_accepts_c%0d", c), 32'(sent), 2);
          chk($sformatf("bp_hold_valid_c%0d", c), 32'(out_valid), 1);
          chk($sformatf("bp_hold_data_c%0d", c), 32'(expo_1), 100);
        end
        if (out_valid && out_ready) begin
          chk($sformatf("bp_order_%0d", recv), 32'(expo_1), 32'(100 + recv));
          ret_cyc[recv] = c;
          recv++;
        end
        if (in_valid && in_ready) sent++;
      end
      in_valid = 1'b0;
      chk("bp_all_received", 32'(recv), 5);
      for (int i = 0; i < 5 && i < recv; i++)
        chk($sformatf("bp_retire_cycle_%0d", i), 32'(ret_cyc[i]), 32'(4 + i));
    end
    @(negedge clk);
    chk("bp_drained", 32'(out_valid), 0);

    // Flush with two items in flight
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      a_expo = 8'(50 + i); b_expo = 8'd127; in_valid = 1'b1;
    end
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("fl_pre_valid", 32'(out_valid), 1);
    chk("fl_in_ready_blocked", 32'(in_ready), 0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("fl_valid_cleared", 32'(out_valid), 0);
    chk("fl_data_kept", 32'(expo_1), 50);
    chk("fl_in_ready_back", 32'(in_ready), 1);
    begin
      int seen = 0;
      repeat (4) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      chk("fl_no_stale", 32'(seen), 0);
    end

    // Reset pulsed mid-stream
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a_expo = 8'(200 + i); b_expo = 8'd127; in_valid = 1'b1;
    end
    @(negedge clk);
    #1;
    chk("rs_pre_valid", 32'(out_valid), 1);
    #1 rst = 1'b1;
    #1;
    chk("rs_async_valid", 32'(out_valid), 0);
    chk("rs_async_data", 32'(|{sign_1, expo_1, zero_nums_uc, mask_short, r_shift, l_shift, spec_cls}), 0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("rs_in_ready", 32'(in_ready), 1);
    begin
      int seen = 0;
      repeat (4) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      chk("rs_no_output", 32'(seen), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
